// File: rtl/rect_pkg.sv
// Shared types and defaults for the rectangle fill engine.
package rect_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exclusive end coordinate, clamped to the visible edge.
  function automatic logic [8:0] clip_end(input logic [8:0] sum, input logic [8:0] lim);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/rect_draw.sv
// Fills an axis-aligned rectangle one pixel per cycle in raster order,
// clipped to the visible screen, for a VGA adapter write port.
module rect_draw
  import rect_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] top_left_x,
  input  logic [6:0] top_left_y,
  input  logic [7:0] width,
  input  logic [6:0] height,
  input  logic [2:0] colour,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [7:0] x_start_q, x_start_d;
  logic [8:0] x_end_q, x_end_d;
  logic [8:0] y_end_q, y_end_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;

  logic [8:0] x_sum;
  logic [8:0] y_sum;
  logic       degenerate;
  logic       x_last;
  logic       y_last;

  // Sums are one bit wider than their operands so a large width never wraps.
  assign x_sum = {1'b0, top_left_x} + {1'b0, width};
  assign y_sum = {2'b00, top_left_y} + {2'b00, height};

  assign degenerate = (width == 8'd0) || (height == 7'd0) ||
                      ({1'b0, top_left_x} >= X_LIM) ||
                      ({2'b00, top_left_y} >= Y_LIM);

  assign x_last = (({1'b0, x_q} + 9'd1) == x_end_q);
  assign y_last = (({2'b00, y_q} + 9'd1) == y_end_q);

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x_start_d = x_start_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    colour_d  = colour_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_start_d = top_left_x;
          x_end_d   = clip_end(x_sum, X_LIM);
          y_end_d   = clip_end(y_sum, Y_LIM);
          colour_d  = colour;
          x_d       = top_left_x;
          y_d       = top_left_y;
          state_d   = degenerate ? DONE : DRAW;
        end
      end

      DRAW: begin
        if (x_last) begin
          x_d = x_start_q;
          if (y_last) begin
            state_d = DONE;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobes are registered alongside the state they belong to.
    plot_d = (state_d == DRAW);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_start_q <= x_start_d;
      x_end_q   <= x_end_d;
      y_end_q   <= y_end_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;

endmodule

// File: doc/rect_draw.md
RECT_DRAW -- requirements
Module: rect_draw

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning visible width in pixels (x range 0..159).
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning visible height in pixels (y range 0..119).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning request to draw one rectangle; level-sensitive.
REQ-006 SHALL have port top_left_x, input, 8, meaning rectangle left column.
REQ-007 SHALL have port top_left_y, input, 7, meaning rectangle top row.
REQ-008 SHALL have port width, input, 8, meaning rectangle width in pixels.
REQ-009 SHALL have port height, input, 7, meaning rectangle height in pixels.
REQ-010 SHALL have port colour, input, 3, meaning fill colour.
REQ-011 SHALL have port done, output, 1, meaning the rectangle is complete.
REQ-012 SHALL have port vga_x, output, 8, meaning pixel column to the VGA adapter.
REQ-013 SHALL have port vga_y, output, 7, meaning pixel row to the VGA adapter.
REQ-014 SHALL have port vga_colour, output, 3, meaning pixel colour to the VGA adapter.
REQ-015 SHALL have port vga_plot, output, 1, meaning write strobe: one pixel per cycle while high.

Function
REQ-016 SHALL implement states IDLE, DRAW, DONE.
REQ-017 IDLE: start sampled high at an edge -> latch all geometry and colour; later input changes are ignored until the next IDLE.
REQ-018 Clipping: x_end = min(top_left_x+width, SCREEN_W); y_end = min(top_left_y+height, SCREEN_H); sums computed 9/8 bits wide, no wrap.
REQ-019 Degenerate (width==0, height==0, top_left_x>=SCREEN_W or top_left_y>=SCREEN_H): IDLE -> DONE directly; zero plots.
REQ-020 Otherwise IDLE -> DRAW with x=top_left_x, y=top_left_y; first plot is in the cycle after the accepting edge.
REQ-021 DRAW: vga_plot=1 every cycle; raster order, x inner (x++ until x_end-1, then x=top_left_x, y++).
REQ-022 After the pixel (x_end-1, y_end-1) is plotted -> DONE; exactly (x_end-top_left_x)*(y_end-top_left_y) plot cycles, no gaps, no duplicates.
REQ-023 vga_x/vga_y SHALL equal the current counters and vga_colour the latched colour; all are don't-care when vga_plot=0.
REQ-024 DONE: done=1, vga_plot=0; stay while start=1; start=0 -> IDLE with done=0 on the next cycle.
REQ-025 done=0 in IDLE and DRAW; start held high across DONE SHALL NOT retrigger a draw.

Reset
REQ-026 rst=1 forces state IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0 immediately, without waiting for a clock edge.
REQ-027 Reset during DRAW abandons the rectangle; after release a new draw needs start sampled high in IDLE.

Structure
REQ-028 Package rect_pkg SHALL hold the state enum (IDLE, DRAW, DONE) and the SCREEN_W/SCREEN_H defaults.
REQ-029 Single module, no sub-modules; one registered FSM plus x/y counters and latched-geometry registers.

Verification
REQ-030 (50,50,w80,h60,colour 3'b011) -> 4800 contiguous plots, first (50,50), last (129,109), done the cycle after the last plot.
REQ-031 (150,110,w20,h20,colour 3'b100) -> 100 plots clipped to x 150..159, y 110..119; no plot with x>=160 or y>=120.
REQ-032 width=0 (any other values) -> done=1 one cycle after start is accepted; zero plots.
REQ-033 (60,40,w50,h30), rst pulsed 10 cycles after start -> vga_plot=0 and done=0 asynchronously; no further plots while start=0.
REQ-034 start held high 200 cycles beyond completion of (0,0,w2,h2) -> 4 plots only, done held; start=0 -> done=0 next cycle.
REQ-035 Back-to-back: (100,70,w40,h20) then (0,0,w160,h120) -> 800 then 19200 plots, each vga_colour equal to its latched value.
